// File: rtl/dht11_sensor_model.sv
// DHT11 sensor-side responder: detects the host start pulse, answers with
// the response preamble and then clocks out a 40-bit frame on an
// open-drain bus. Intended as a loop-back stimulus for the dht11 receiver.
//
// Handshake/bus semantics: dq_oe=1 pulls the bus low, dq_oe=0 releases it.
// All bus decisions use dq_s, the 2-flop synchronised copy of dht11.
module dht11_sensor_model #(
  parameter int US_CYC      = 1,
  parameter int T_START_MIN = 18,
  parameter int T_WAIT      = 30,
  parameter int T_RESP_LOW  = 80,
  parameter int T_RESP_HIGH = 80,
  parameter int T_BIT_LOW   = 50,
  parameter int T_ZERO_HIGH = 26,
  parameter int T_ONE_HIGH  = 70
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dht11,
  output logic       dq_oe,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] checksum,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE           = 4'd0,
    S_HOST_LOW       = 4'd1,
    S_WAIT           = 4'd2,
    S_RESP_LOW       = 4'd3,
    S_RESP_HIGH      = 4'd4,
    S_BIT_LOW        = 4'd5,
    S_BIT_HIGH       = 4'd6,
    S_END_LOW        = 4'd7,
    S_IDLE_WAIT_HIGH = 4'd8
  } state_t;

  localparam logic [15:0] LEN_WAIT      = 16'(T_WAIT * US_CYC);
  localparam logic [15:0] LEN_RESP_LOW  = 16'(T_RESP_LOW * US_CYC);
  localparam logic [15:0] LEN_RESP_HIGH = 16'(T_RESP_HIGH * US_CYC);
  localparam logic [15:0] LEN_BIT_LOW   = 16'(T_BIT_LOW * US_CYC);
  localparam logic [15:0] LEN_ZERO      = 16'(T_ZERO_HIGH * US_CYC);
  localparam logic [15:0] LEN_ONE       = 16'(T_ONE_HIGH * US_CYC);
  // The IDLE cycle already saw the first low sample, so HOST_LOW holds
  // (low length - 1) when the bus is released.
  localparam logic [15:0] START_THR     = 16'(T_START_MIN * US_CYC - 1);
  // Released phases ignore the bus this many cycles while dq_s catches up.
  localparam logic [15:0] GUARD         = 16'd3;

  state_t      state_q, state_d;
  logic        sync1, dq_s;
  logic [15:0] cnt;
  logic [5:0]  idx;
  logic [39:0] frame;
  logic [15:0] phase_len;
  logic        phase_last;
  logic        collide;
  logic        accept;
  logic [7:0]  sum;

  assign state  = state_q;
  assign sum    = hum_int + hum_dec + temp_int + temp_dec;
  assign accept = (state_q == S_HOST_LOW) && (state_d == S_WAIT);

  // Length of the current timed phase and the collision detector
  always_comb begin
    phase_len = 16'd0;
    case (state_q)
      S_WAIT:      phase_len = LEN_WAIT;
      S_RESP_LOW:  phase_len = LEN_RESP_LOW;
      S_RESP_HIGH: phase_len = LEN_RESP_HIGH;
      S_BIT_LOW:   phase_len = LEN_BIT_LOW;
      S_BIT_HIGH:  phase_len = frame[idx] ? LEN_ONE : LEN_ZERO;
      S_END_LOW:   phase_len = LEN_BIT_LOW;
      default:     phase_len = 16'd0;
    endcase
    phase_last = (cnt == phase_len - 16'd1);
    collide    = ((state_q == S_WAIT) || (state_q == S_RESP_HIGH) ||
                  (state_q == S_BIT_HIGH)) && (cnt >= GUARD) && !dq_s;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (!dq_s) state_d = S_HOST_LOW;
      S_HOST_LOW:  if (dq_s) state_d = (cnt >= START_THR) ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (collide)         state_d = S_IDLE_WAIT_HIGH;
        else if (phase_last) state_d = S_RESP_LOW;
      end
      S_RESP_LOW:  if (phase_last) state_d = S_RESP_HIGH;
      S_RESP_HIGH: begin
        if (collide)         state_d = S_IDLE_WAIT_HIGH;
        else if (phase_last) state_d = S_BIT_LOW;
      end
      S_BIT_LOW:   if (phase_last) state_d = S_BIT_HIGH;
      S_BIT_HIGH: begin
        if (collide)         state_d = S_IDLE_WAIT_HIGH;
        else if (phase_last) state_d = (idx == 6'd0) ? S_END_LOW : S_BIT_LOW;
      end
      S_END_LOW:        if (phase_last) state_d = S_IDLE;
      S_IDLE_WAIT_HIGH: if (dq_s) state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase
  end

  // Output decode: the bus is pulled low only in the driven phases
  always_comb begin
    dq_oe = 1'b0;
    case (state_q)
      S_RESP_LOW, S_BIT_LOW, S_END_LOW: dq_oe = 1'b1;
      default:                          dq_oe = 1'b0;
    endcase
  end

  // Synchroniser, phase counter, bit index, frame latch and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b1;
      dq_s     <= 1'b1;
      cnt      <= 16'd0;
      idx      <= 6'd0;
      frame    <= 40'd0;
      checksum <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      sync1 <= dht11;
      dq_s  <= sync1;
      if (state_d != state_q)  cnt <= 16'd0;
      else if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      if (state_q == S_RESP_HIGH && state_d == S_BIT_LOW)     idx <= 6'd39;
      else if (state_q == S_BIT_HIGH && state_d == S_BIT_LOW) idx <= idx - 6'd1;
      done <= (state_q == S_END_LOW) && (state_d == S_IDLE);
      err  <= collide;
      if (accept) begin
        frame    <= {hum_int, hum_dec, temp_int, temp_dec, sum};
        checksum <= sum;
        busy     <= 1'b1;
      end else if (collide || ((state_q == S_END_LOW) && (state_d == S_IDLE))) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dht11_sensor_model.sv
// Directed bench for dht11_sensor_model: a host model drives the start
// pulse on a wired-AND bus, frames are decoded from dq_oe run lengths and
// compared against hand-computed expected frames.
module tb_dht11_sensor_model;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_BIT_LOW  = 4'd5;
  localparam logic [3:0] ST_BIT_HIGH = 4'd6;
  localparam logic [3:0] ST_IWH      = 4'd8;

  logic       clk;
  logic       rst;
  logic       host_low;
  logic       dht11;
  logic       dq_oe;
  logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
  logic       busy, done, err;
  logic [7:0] checksum;
  logic [3:0] state;

  int vectors     = 0;
  int miscompares = 0;
  logic [39:0] exp_q[$];

  // Open-drain bus with pull-up: low if either side pulls it
  assign dht11 = ~(dq_oe | host_low);

  dht11_sensor_model dut (
    .clk      (clk),
    .rst      (rst),
    .dht11    (dht11),
    .dq_oe    (dq_oe),
    .hum_int  (hum_int),
    .hum_dec  (hum_dec),
    .temp_int (temp_int),
    .temp_dec (temp_dec),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .checksum (checksum),
    .state    (state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic host_start(input int n);
    host_low = 1'b1;
    repeat (n) @(negedge clk);
    host_low = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] s, input string tag);
    int n = 0;
    while (state !== s && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 40'(state === s), 40'd1);
  endtask

  // Host start followed by a bounded capture of dq_oe run lengths
  task automatic run_frame(input int low_cycles, input bit mid_change,
                           output logic [39:0] bits, output int n_runs,
                           output int wait_run, output int resp_lo, output int resp_hi,
                           output int bad_lows, output int bad_highs, output int end_lo,
                           output int done_cnt, output int err_cnt, output int busy_gaps);
    int   runs[$];
    logic lvl;
    int   len;
    int   cyc;
    bit   seen_done;
    host_start(low_cycles);
    lvl = 1'b0; len = 0; cyc = 0; seen_done = 0;
    done_cnt = 0; err_cnt = 0; busy_gaps = 0; bad_lows = 0; bad_highs = 0;
    bits = 40'd0; wait_run = -1; resp_lo = -1; resp_hi = -1; end_lo = -1;
    while (!seen_done && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (mid_change && runs.size() == 1 && dq_oe) temp_int = 8'hAA;
      if (dq_oe !== lvl) begin
        runs.push_back(len);
        lvl = dq_oe;
        len = 1;
      end else begin
        len++;
      end
      if (done) begin done_cnt++; seen_done = 1; end
      if (err) err_cnt++;
      if (dq_oe && !busy) busy_gaps++;
    end
    repeat (20) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (err) err_cnt++;
    end
    n_runs = runs.size();
    if (n_runs >= 84) begin
      wait_run = runs[0];
      resp_lo  = runs[1];
      resp_hi  = runs[2];
      for (int i = 0; i < 40; i++) begin
        if (runs[3 + 2 * i] != 50) bad_lows++;
        if (runs[4 + 2 * i] != 26 && runs[4 + 2 * i] != 70) bad_highs++;
        bits[39 - i] = (runs[4 + 2 * i] > 48);
      end
      end_lo = runs[83];
    end
  endtask

  task automatic frame_checks(input string tag, input int low_cycles, input bit mid_change,
                              input logic [7:0] exp_sum);
    logic [39:0] bits;
    int n_runs, wait_run, resp_lo, resp_hi, bad_lows, bad_highs, end_lo;
    int done_cnt, err_cnt, busy_gaps;
    run_frame(low_cycles, mid_change, bits, n_runs, wait_run, resp_lo, resp_hi,
              bad_lows, bad_highs, end_lo, done_cnt, err_cnt, busy_gaps);
    check({tag, "_runs"},      40'(n_runs),    40'd84);
    check({tag, "_wait_run"},  40'(wait_run),  40'd32);
    check({tag, "_resp_low"},  40'(resp_lo),   40'd80);
    check({tag, "_resp_high"}, 40'(resp_hi),   40'd80);
    check({tag, "_bit_lows"},  40'(bad_lows),  40'd0);
    check({tag, "_bit_highs"}, 40'(bad_highs), 40'd0);
    check({tag, "_end_low"},   40'(end_lo),    40'd50);
    check({tag, "_bits"},      bits,           exp_q.pop_front());
    check({tag, "_checksum"},  40'(checksum),  40'(exp_sum));
    check({tag, "_done_cnt"},  40'(done_cnt),  40'd1);
    check({tag, "_err_cnt"},   40'(err_cnt),   40'd0);
    check({tag, "_busy_gaps"}, 40'(busy_gaps), 40'd0);
    check({tag, "_busy_after"}, 40'(busy),     40'd0);
  endtask

  // Directed sequence
  initial begin
    int activity, err_cnt, err_lat, bad, done_cnt;
    rst = 1'b1; host_low = 1'b0;
    hum_int = 8'h00; hum_dec = 8'h00; temp_int = 8'h00; temp_dec = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_dq_oe",    40'(dq_oe),    40'd0);
    check("rst_busy",     40'(busy),     40'd0);
    check("rst_done",     40'(done),     40'd0);
    check("rst_err",      40'(err),      40'd0);
    check("rst_checksum", 40'(checksum), 40'd0);
    check("rst_state",    40'(state),    40'(ST_IDLE));
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Normal frame
    hum_int = 8'h2D; hum_dec = 8'h00; temp_int = 8'h19; temp_dec = 8'h05;
    exp_q.push_back(40'h2D_00_19_05_4B);
    frame_checks("normal", 20, 1'b0, 8'h4B);

    // Checksum wrap
    hum_int = 8'hFF; hum_dec = 8'h01; temp_int = 8'h00; temp_dec = 8'h00;
    exp_q.push_back(40'hFF_01_00_00_00);
    frame_checks("wrap", 20, 1'b0, 8'h00);

    // Short start pulse is ignored
    hum_int = 8'h2D; hum_dec = 8'h00; temp_int = 8'h19; temp_dec = 8'h05;
    host_start(17);
    activity = 0;
    repeat (60) begin
      @(negedge clk);
      if (dq_oe || busy || err) activity++;
    end
    check("short_activity", 40'(activity), 40'd0);
    check("short_state",    40'(state),    40'(ST_IDLE));

    // Data change during RESP_LOW does not reach the frame
    exp_q.push_back(40'h2D_00_19_05_4B);
    frame_checks("midchg", 20, 1'b1, 8'h4B);
    temp_int = 8'h19;

    // Collision in the first BIT_HIGH
    host_start(20);
    wait_state(ST_BIT_HIGH, "coll_reach_bit_high");
    repeat (10) @(negedge clk);
    host_low = 1'b1;
    err_cnt = 0; err_lat = 0; bad = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (err) begin
        err_cnt++;
        if (err_lat == 0) err_lat = k;
      end
      if (k > 3 && (dq_oe || busy)) bad++;
    end
    check("coll_err_cnt",   40'(err_cnt), 40'd1);
    check("coll_err_lat",   40'(err_lat >= 1 && err_lat <= 3), 40'd1);
    check("coll_released",  40'(bad), 40'd0);
    check("coll_state_iwh", 40'(state), 40'(ST_IWH));
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (dq_oe || busy || state !== ST_IWH) bad++;
    end
    check("coll_hold_low", 40'(bad), 40'd0);
    host_low = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (dq_oe || busy || err || done) bad++;
    end
    check("coll_no_restart", 40'(bad),   40'd0);
    check("coll_state_idle", 40'(state), 40'(ST_IDLE));

    // Reset during BIT_LOW
    host_start(20);
    wait_state(ST_BIT_LOW, "rstmid_reach_bit_low");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_dq_oe",    40'(dq_oe),    40'd0);
    check("rstmid_busy",     40'(busy),     40'd0);
    check("rstmid_done",     40'(done),     40'd0);
    check("rstmid_state",    40'(state),    40'(ST_IDLE));
    check("rstmid_checksum", 40'(checksum), 40'd0);
    rst = 1'b0;
    done_cnt = 0; bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (dq_oe || err) bad++;
    end
    check("rstmid_no_done", 40'(done_cnt), 40'd0);
    check("rstmid_quiet",   40'(bad),      40'd0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
